// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulator for the 64-channel Layer3 stage: sums a programmable
// number of group beats per pixel, hands each pixel downstream, counts pixels per frame.
module psum_accum_ctrl #(
   parameter int CH         = 64,
   parameter int IN_W       = 8,
   parameter int MAX_GROUPS = 4,
   parameter int ACC_W      = 10,
   parameter int PIX_W      = 12
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic [$clog2(MAX_GROUPS):0]   cfg_groups,
   input  logic [PIX_W-1:0]              cfg_pixels,
   input  logic                          psum_valid,
   input  logic [CH*IN_W-1:0]            psum_data,
   output logic                          psum_ready,
   output logic                          acc_valid,
   output logic [CH*ACC_W-1:0]           acc_data,
   input  logic                          acc_ready,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int GW = $clog2(MAX_GROUPS) + 1;
   localparam logic [GW-1:0] MAX_G = GW'(MAX_GROUPS);

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   state_t           state_reg;
   logic [GW-1:0]    groups_reg;
   logic [GW-1:0]    grp_cnt_reg;
   logic [PIX_W-1:0] pixels_reg;
   logic [PIX_W-1:0] pix_cnt_reg;
   logic             frame_done_reg;
   logic [GW-1:0]    groups_eff;
   logic             beat;
   logic             first_beat;

   // A group count of 0 means one beat; anything above the hardware limit saturates.
   always_comb begin
      groups_eff = cfg_groups;
      if (cfg_groups == '0)
         groups_eff = GW'(1);
      else if (cfg_groups > MAX_G)
         groups_eff = MAX_G;
   end

   assign beat       = (state_reg == ACCUM) && psum_valid;
   assign first_beat = (grp_cnt_reg == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg      <= IDLE;
         groups_reg     <= GW'(1);
         grp_cnt_reg    <= '0;
         pixels_reg     <= '0;
         pix_cnt_reg    <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  groups_reg  <= groups_eff;
                  pixels_reg  <= cfg_pixels;
                  grp_cnt_reg <= '0;
                  pix_cnt_reg <= '0;
                  // An empty frame completes immediately without ever leaving IDLE.
                  if (cfg_pixels == '0)
                     frame_done_reg <= 1'b1;
                  else
                     state_reg <= ACCUM;
               end
            end
            ACCUM: begin
               if (psum_valid) begin
                  if (grp_cnt_reg == groups_reg - GW'(1)) begin
                     grp_cnt_reg <= '0;
                     state_reg   <= OUT;
                  end else begin
                     grp_cnt_reg <= grp_cnt_reg + GW'(1);
                  end
               end
            end
            OUT: begin
               if (acc_ready) begin
                  if (pix_cnt_reg == pixels_reg - PIX_W'(1)) begin
                     pix_cnt_reg    <= '0;
                     frame_done_reg <= 1'b1;
                     state_reg      <= IDLE;
                  end else begin
                     pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
                     state_reg   <= ACCUM;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign psum_ready = (state_reg == ACCUM);
   assign acc_valid  = (state_reg == OUT);
   assign busy       = (state_reg != IDLE);
   assign frame_done = frame_done_reg;

   // One accumulator per channel; the first beat of a pixel overwrites instead of adding.
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_lane
         logic signed [IN_W-1:0]  lane_in;
         logic signed [ACC_W-1:0] acc_reg;

         assign lane_in = psum_data[gi*IN_W +: IN_W];

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
               acc_reg <= '0;
            else if (beat)
               acc_reg <= first_beat ? ACC_W'(lane_in) : acc_reg + ACC_W'(lane_in);
         end

         assign acc_data[gi*ACC_W +: ACC_W] = acc_reg;
      end
   endgenerate

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench for psum_accum_ctrl: stimulus pushes expected pixel sums,
// a negedge monitor pops and compares whenever a pixel is handed downstream.
module tb_psum_accum_ctrl;

   localparam int CH    = 64;
   localparam int IN_W  = 8;
   localparam int MAXG  = 4;
   localparam int ACC_W = 10;
   localparam int PIX_W = 12;
   localparam int GW    = $clog2(MAXG) + 1;

   localparam int M_RAND  = 0;
   localparam int M_MIN   = 1;
   localparam int M_MAX   = 2;
   localparam int M_BASIC = 3;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 start;
   logic [GW-1:0]        cfg_groups;
   logic [PIX_W-1:0]     cfg_pixels;
   logic                 psum_valid;
   logic [CH*IN_W-1:0]   psum_data;
   logic                 psum_ready;
   logic                 acc_valid;
   logic [CH*ACC_W-1:0]  acc_data;
   logic                 acc_ready;
   logic                 busy;
   logic                 frame_done;

   psum_accum_ctrl #(
      .CH(CH), .IN_W(IN_W), .MAX_GROUPS(MAXG), .ACC_W(ACC_W), .PIX_W(PIX_W)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_groups(cfg_groups),
      .cfg_pixels(cfg_pixels), .psum_valid(psum_valid), .psum_data(psum_data),
      .psum_ready(psum_ready), .acc_valid(acc_valid), .acc_data(acc_data),
      .acc_ready(acc_ready), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int frames_exp = 0;
   int fd_count   = 0;
   int force_hold = 0;
   int pix_seen   = 0;

   logic [CH*ACC_W-1:0] exp_q[$];
   bit                  last_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [CH*ACC_W-1:0] act,
                          input logic [CH*ACC_W-1:0] exp);
      logic signed [ACC_W-1:0] la, le;
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         for (int k = 0; k < CH; k++) begin
            la = act[k*ACC_W +: ACC_W];
            le = exp[k*ACC_W +: ACC_W];
            if (la !== le) begin
               $display("FAIL %s: lane %0d got %0d, expected %0d", name, k, la, le);
               break;
            end
         end
      end
   endtask

   // Downstream ready: random, except when the stimulus asks for a long stall.
   initial begin
      acc_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (force_hold > 0) begin
            acc_ready = 1'b0;
            force_hold--;
         end else begin
            acc_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: pops one expected pixel per downstream handshake.
   initial begin
      bit pend = 0, pend_last = 0, prev_hold = 0, fd_prev = 0;
      logic [CH*ACC_W-1:0] prev_data = '0;
      logic [CH*ACC_W-1:0] e;
      bit l;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend = 0; prev_hold = 0; fd_prev = 0;
         end else begin
            if (pend) begin
               chk("acc_valid_drop", acc_valid, 0);
               if (pend_last) begin
                  chk("frame_done_after_last", frame_done, 1);
                  chk("busy_after_last", busy, 0);
               end else begin
                  chk("psum_ready_next_pixel", psum_ready, 1);
               end
               pend = 0;
            end
            if (frame_done) begin
               fd_count++;
               chk("frame_done_width", fd_prev, 0);
            end
            fd_prev = frame_done;
            if (acc_valid) begin
               chk("psum_ready_in_out", psum_ready, 0);
               if (prev_hold) chk_vec("acc_data_stable", acc_data, prev_data);
               if (acc_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_pixel", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     l = last_q.pop_front();
                     chk_vec("pixel_sum", acc_data, e);
                     $display("pixel %0d lane0=%0d lane63=%0d last=%0d", pix_seen,
                              $signed(acc_data[0 +: ACC_W]),
                              $signed(acc_data[63*ACC_W +: ACC_W]), l);
                     pix_seen++;
                     pend = 1; pend_last = l;
                  end
                  prev_hold = 0;
               end else begin
                  prev_hold = 1;
                  prev_data = acc_data;
               end
            end else begin
               prev_hold = 0;
            end
         end
      end
   end

   task automatic send_beat(input logic [CH*IN_W-1:0] b, input bit last);
      int w;
      repeat (1 + $urandom_range(0, 2)) @(posedge clk);
      #1;
      psum_valid = 1'b1;
      psum_data  = b;
      w = 0;
      forever begin
         @(negedge clk);
         if (psum_ready) break;
         w++;
         if (w > 500) begin
            chk("beat_accept_timeout", 0, 1);
            psum_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      psum_valid = 1'b0;
      psum_data  = '0;
      if (last) begin
         @(negedge clk);
         chk("acc_valid_after_last_beat", acc_valid, 1);
      end
   endtask

   task automatic pulse_start(input int g, input int p);
      @(posedge clk);
      #1;
      start = 1'b1;
      cfg_groups = GW'(g);
      cfg_pixels = PIX_W'(p);
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_groups = GW'($urandom_range(0, 7));
      cfg_pixels = PIX_W'($urandom_range(0, 9));
   endtask

   function automatic int lane_val(input int mode, input int k, input int b);
      int basic[4];
      basic[0] = 3; basic[1] = -5; basic[2] = 7; basic[3] = -1;
      case (mode)
         M_MIN:   return -128;
         M_MAX:   return 127;
         M_BASIC: begin
            if (k == 0) return basic[b];
            if (k == 63) return -16;
            return int'($urandom_range(0, 255)) - 128;
         end
         default: return int'($urandom_range(0, 255)) - 128;
      endcase
   endfunction

   task automatic run_frame(input int g_cfg, input int pix, input int mode,
                            input bit mid_start, input bit stall);
      int geff, w, v;
      int sums[CH];
      logic [CH*IN_W-1:0]  b_v;
      logic [CH*ACC_W-1:0] e_v;
      geff = (g_cfg == 0) ? 1 : ((g_cfg > MAXG) ? MAXG : g_cfg);
      w = 0;
      while (busy && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (busy) chk("idle_wait_timeout", busy, 0);
      $display("frame start groups=%0d pixels=%0d mode=%0d", g_cfg, pix, mode);
      pulse_start(g_cfg, pix);
      frames_exp++;
      @(negedge clk);
      if (pix == 0) begin
         chk("empty_frame_done", frame_done, 1);
         chk("empty_frame_busy", busy, 0);
         chk("empty_frame_ready", psum_ready, 0);
      end else begin
         chk("start_busy", busy, 1);
         chk("start_psum_ready", psum_ready, 1);
      end
      for (int p = 0; p < pix; p++) begin
         for (int k = 0; k < CH; k++) sums[k] = 0;
         for (int b = 0; b < geff; b++) begin
            for (int k = 0; k < CH; k++) begin
               v = lane_val(mode, k, b);
               b_v[k*IN_W +: IN_W] = v[IN_W-1:0];
               sums[k] += v;
            end
            if (b == geff - 1) begin
               for (int k = 0; k < CH; k++) e_v[k*ACC_W +: ACC_W] = sums[k][ACC_W-1:0];
               exp_q.push_back(e_v);
               last_q.push_back(p == pix - 1);
               if (stall) force_hold = 8;
            end
            send_beat(b_v, b == geff - 1);
            if (mid_start && p == 0 && b == 0)
               pulse_start(1, pix + 3);
         end
      end
   endtask

   initial begin
      logic [CH*ACC_W-1:0] zero_v;
      logic [CH*IN_W-1:0]  junk;
      int w;
      zero_v = '0;
      rstn = 1'b0; start = 1'b0; cfg_groups = '0; cfg_pixels = '0;
      psum_valid = 1'b0; psum_data = '0;
      repeat (3) @(negedge clk);
      chk("reset_psum_ready", psum_ready, 0);
      chk("reset_acc_valid", acc_valid, 0);
      chk_vec("reset_acc_data", acc_data, zero_v);
      chk("reset_busy", busy, 0);
      chk("reset_frame_done", frame_done, 0);
      rstn = 1'b1;

      // Abort a frame after two of four beats; the restarted pixel must not include them.
      pulse_start(4, 1);
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < CH; k++) junk[k*IN_W +: IN_W] = 8'(100 + b);
         send_beat(junk, 0);
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midreset_psum_ready", psum_ready, 0);
      chk("midreset_acc_valid", acc_valid, 0);
      chk_vec("midreset_acc_data", acc_data, zero_v);
      chk("midreset_busy", busy, 0);
      chk("midreset_frame_done", frame_done, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      run_frame(4, 1, M_RAND, 0, 0);

      run_frame(4, 2, M_BASIC, 0, 0);
      run_frame(3, 3, M_RAND, 0, 1);
      run_frame(0, 3, M_RAND, 0, 0);
      run_frame(7, 2, M_RAND, 0, 0);
      run_frame(2, 0, M_RAND, 0, 0);
      run_frame(4, 1, M_MIN, 0, 0);
      run_frame(4, 1, M_MAX, 0, 0);
      run_frame(2, 3, M_RAND, 1, 0);
      for (int i = 0; i < 6; i++)
         run_frame($urandom_range(0, 7), $urandom_range(0, 4), M_RAND, 0, $urandom_range(0, 1) == 1);

      w = 0;
      while (busy && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk("final_idle", busy, 0);
      repeat (4) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("frame_done_count", fd_count, frames_exp);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
